// File: rtl/jk_register_bank.sv
// jk_register_bank
//   WIDTH-bit bank of JK cells on one clock. The bank supports four modes:
//   hold, per-bit JK, up/down count and parallel load.
//   The count mode is built as a JK toggle chain. TC is a combinational
//   look-ahead of the wrap. CARRY is a registered one-cycle pulse after the wrap.
//   Optional feature: define JK_REGISTER_BANK_SYNC_CLR_EN to add the
//   active-low synchronous clear input SYNC_CLRL.
module jk_register_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             MasterClock,
  input  logic             RESETL,
`ifdef JK_REGISTER_BANK_SYNC_CLR_EN
  input  logic             SYNC_CLRL,
`endif
  input  logic             CE,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] KL,
  input  logic [WIDTH-1:0] D,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QL,
  output logic             TC,
  output logic             CARRY
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_JK    = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] cnt_next;
  logic             wrap;
  logic             clr;

  assign mode = mode_e'(MODE);

`ifdef JK_REGISTER_BANK_SYNC_CLR_EN
  assign clr = ~SYNC_CLRL;
`else
  assign clr = 1'b0;
`endif

  // Toggle chain: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output
    // first, so no path leaves a signal unassigned and no latch is inferred.
    toggle    = '0;
    toggle[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & (UP ? q_q[i-1] : ~q_q[i-1]);
    end
  end

  // Count result, wrap detect and per-bit JK result.
  assign cnt_next = q_q ^ toggle;
  assign wrap     = UP ? (&q_q) : ~(|q_q);
  assign jk_next  = (J & ~q_q) | (KL & q_q);   // J sets/toggles a 0, ~K keeps a 1

  // Terminal count is the look-ahead of the CARRY pulse on the next edge.
  assign TC = (mode == MODE_COUNT) & CE & wrap & ~clr;

  // Next-state selection: sync clear > clock enable > mode.
  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (CE) begin
      unique case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_JK:    q_d = jk_next;
        MODE_COUNT: begin
          q_d     = cnt_next;
          carry_d = wrap;
        end
        MODE_LOAD:  q_d = D;
        default:    q_d = q_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    if (!RESETL) begin
      q_q     <= RESET_VAL;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  assign Q     = q_q;
  assign QL    = ~q_q;
  assign CARRY = carry_q;

endmodule
